// File: rtl/cpu_io_pkg.sv
// Shared defaults, serializer state encoding and byte-lane helper for the CPU output streamer.
package cpu_io_pkg;

  localparam int DATAWIDTH_DEF = 25;
  localparam int DEPTH_DEF     = 8;
  localparam int SHIFT_W       = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  // Lane 0 is the most significant byte, so bytes leave MSB first.
  function automatic logic [7:0] pick_byte(input logic [SHIFT_W-1:0] word,
                                           input logic [1:0]         idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous word FIFO: write and read at the same edge, head visible combinationally.
// A push while full only lands when a pop frees the slot at that edge.
module io_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign rd_en = pop && !empty;
  assign wr_en = push && !reset && (!full || rd_en);

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/cpu_output_streamer.sv
// Buffers CPU result words and streams each one as four MSB-first bytes on a valid/ready port.
// First byte is valid one edge after the capturing edge; byteValid is registered, ready only advances it.
module cpu_output_streamer
  import cpu_io_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   outFlagIOE,
  input  logic [DATAWIDTH-1:0]   out,
  output logic [7:0]             byteData,
  output logic                   byteValid,
  input  logic                   byteReady,
  output logic                   fifoFull,
  output logic                   fifoEmpty,
  output logic [$clog2(DEPTH):0] wordCount,
  output logic                   overflow
);

  ser_state_e           state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic                 ovf_q, ovf_d;
  logic [DATAWIDTH-1:0] head_word;
  logic                 fire, last_byte, pop, drop;

  io_fifo #(
    .WIDTH (DATAWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (outFlagIOE),
    .wr_data (out),
    .pop     (pop),
    .rd_data (head_word),
    .full    (fifoFull),
    .empty   (fifoEmpty),
    .count   (wordCount)
  );

  assign fire      = (state_q == SEND) && byteReady;
  assign last_byte = fire && (idx_q == 2'd3);
  // Reload straight after the last byte so back-to-back words leave no bubble.
  assign pop       = !fifoEmpty && ((state_q == IDLE) || last_byte);
  assign drop      = outFlagIOE && fifoFull && !pop;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    ovf_d   = ovf_q | drop;
    if (pop) begin
      shift_d = SHIFT_W'(head_word);
      idx_d   = 2'd0;
      state_d = SEND;
    end else if (last_byte) begin
      idx_d   = 2'd0;
      state_d = IDLE;
    end else if (fire) begin
      idx_d   = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
    end
  end

  assign byteValid = (state_q == SEND);
  assign byteData  = pick_byte(shift_q, idx_q);
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_cpu_output_streamer.sv
// Directed and random checks of the output streamer against a queue-based byte-stream model.
module tb_cpu_output_streamer;

  localparam int DW    = 25;
  localparam int DEPTH = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          outFlagIOE;
  logic [DW-1:0] out;
  logic [7:0]    byteData;
  logic          byteValid;
  logic          byteReady;
  logic          fifoFull;
  logic          fifoEmpty;
  logic [3:0]    wordCount;
  logic          overflow;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] m_fifo [$];
  logic [7:0]    m_cur  [$];
  bit            m_ovf;

  logic [7:0] exp30 [4] = '{8'h01, 8'hAB, 8'hCD, 8'hEF};
  logic [7:0] exp31 [8] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};

  cpu_output_streamer #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .outFlagIOE (outFlagIOE),
    .out        (out),
    .byteData   (byteData),
    .byteValid  (byteValid),
    .byteReady  (byteReady),
    .fifoFull   (fifoFull),
    .fifoEmpty  (fifoEmpty),
    .wordCount  (wordCount),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the stream: hand over a byte, refill an empty shifter, then accept or drop the strobe.
  task automatic model_edge(input bit rst, input bit stb, input bit rdy, input logic [DW-1:0] d);
    logic [31:0]   w;
    logic [DW-1:0] hd;
    if (rst) begin
      m_fifo.delete();
      m_cur.delete();
      m_ovf = 1'b0;
      return;
    end
    if (m_cur.size() != 0 && rdy) m_cur.delete(0);
    if (m_cur.size() == 0 && m_fifo.size() != 0) begin
      hd = m_fifo.pop_front();
      w  = 32'(hd);
      for (int k = 3; k >= 0; k--) m_cur.push_back(w[8*k +: 8]);
    end
    if (stb) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_model();
    chk("m_valid", 32'(byteValid), 32'(m_cur.size() != 0));
    if (m_cur.size() != 0) chk("m_data", 32'(byteData), 32'(m_cur[0]));
    chk("m_count", 32'(wordCount), 32'(m_fifo.size()));
    chk("m_full",  32'(fifoFull),  32'(m_fifo.size() == DEPTH));
    chk("m_empty", 32'(fifoEmpty), 32'(m_fifo.size() == 0));
    chk("m_ovf",   32'(overflow),  32'(m_ovf));
  endtask

  task automatic step();
    bit            r, s, y;
    logic [DW-1:0] d;
    r = reset;
    s = outFlagIOE;
    y = byteReady;
    d = out;
    @(posedge clock);
    model_edge(r, s, y, d);
    #1;
    check_model();
  endtask

  initial begin
    reset      = 1'b1;
    outFlagIOE = 1'b1;
    out        = 25'h1555555;
    byteReady  = 1'b1;
    #1;
    step();
    step();
    chk("rst_valid", 32'(byteValid), 32'd0);
    chk("rst_data",  32'(byteData),  32'd0);
    chk("rst_count", 32'(wordCount), 32'd0);
    chk("rst_empty", 32'(fifoEmpty), 32'd1);
    chk("rst_full",  32'(fifoFull),  32'd0);
    chk("rst_ovf",   32'(overflow),  32'd0);

    // Single word, ready held high.
    reset      = 1'b0;
    out        = 25'h1ABCDEF;
    outFlagIOE = 1'b1;
    step();
    outFlagIOE = 1'b0;
    chk("one_n_valid", 32'(byteValid), 32'd0);
    chk("one_n_count", 32'(wordCount), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("one_valid", 32'(byteValid), 32'd1);
      chk("one_byte",  32'(byteData),  32'(exp30[i]));
    end
    step();
    chk("one_end_valid", 32'(byteValid), 32'd0);

    // Two back-to-back words, no bubble between them.
    outFlagIOE = 1'b1;
    out        = 25'h0000001;
    step();
    out        = 25'h1000000;
    step();
    outFlagIOE = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_valid", 32'(byteValid), 32'd1);
      chk("b2b_byte",  32'(byteData),  32'(exp31[i]));
      step();
    end
    chk("b2b_end_valid", 32'(byteValid), 32'd0);

    // Downstream stall mid-word.
    outFlagIOE = 1'b1;
    out        = 25'h0123456;
    step();
    outFlagIOE = 1'b0;
    step();
    step();
    byteReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", 32'(byteValid), 32'd1);
      chk("stall_byte",  32'(byteData),  32'h12);
    end
    byteReady = 1'b1;
    step();
    chk("resume_b2", 32'(byteData), 32'h34);
    step();
    chk("resume_b3", 32'(byteData), 32'h56);
    step();
    chk("resume_end", 32'(byteValid), 32'd0);

    // Overfill with ready low: one word in the shifter, eight stored, one dropped.
    byteReady  = 1'b0;
    outFlagIOE = 1'b1;
    for (int i = 0; i < 10; i++) begin
      out = DW'($urandom);
      step();
    end
    outFlagIOE = 1'b0;
    chk("ovf_count", 32'(wordCount), 32'd8);
    chk("ovf_full",  32'(fifoFull),  32'd1);
    chk("ovf_flag",  32'(overflow),  32'd1);
    chk("ovf_valid", 32'(byteValid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ovf_sticky", 32'(overflow), 32'd1);
    end

    // Reset after byte 1 has transferred, with a strobe in the reset cycle.
    byteReady = 1'b1;
    step();
    step();
    reset      = 1'b1;
    outFlagIOE = 1'b1;
    step();
    chk("mid_rst_valid", 32'(byteValid), 32'd0);
    chk("mid_rst_count", 32'(wordCount), 32'd0);
    chk("mid_rst_empty", 32'(fifoEmpty), 32'd1);
    chk("mid_rst_ovf",   32'(overflow),  32'd0);
    chk("mid_rst_data",  32'(byteData),  32'd0);
    reset      = 1'b0;
    outFlagIOE = 1'b0;
    step();
    chk("rst_strobe_ignored", 32'(wordCount), 32'd0);
    chk("rst_no_partial",     32'(byteValid), 32'd0);

    // Strobe while full on the edge that pops the next word.
    byteReady  = 1'b0;
    outFlagIOE = 1'b1;
    for (int i = 0; i < 9; i++) begin
      out = DW'($urandom);
      step();
    end
    outFlagIOE = 1'b0;
    chk("fp_pre_count", 32'(wordCount), 32'd8);
    chk("fp_pre_ovf",   32'(overflow),  32'd0);
    byteReady = 1'b1;
    for (int i = 0; i < 3; i++) step();
    outFlagIOE = 1'b1;
    out        = 25'h0F0F0F0;
    step();
    outFlagIOE = 1'b0;
    chk("fp_count", 32'(wordCount), 32'd8);
    chk("fp_full",  32'(fifoFull),  32'd1);
    chk("fp_ovf",   32'(overflow),  32'd0);
    chk("fp_valid", 32'(byteValid), 32'd1);
    for (int i = 0; i < 40; i++) step();

    // Random traffic: a fill-heavy phase, then a drain-heavy phase, with rare resets.
    for (int i = 0; i < 800; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      outFlagIOE = (i < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      byteReady  = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      out        = DW'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
